// File: rtl/seg_scan.sv
// Multiplexed seven-segment driver: scans DIGITS hex nibbles onto a shared segment bus,
// with frame-synchronous double buffering, decimal points, leading-zero blanking and blink.
module seg_scan #(
  parameter int DIGITS         = 4,
  parameter int DWELL          = 100000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blink_en,
  input  logic                blank_lz,
  input  logic                load,
  output logic [DIGITS-1:0]   choose,
  output logic [7:0]          seg,
  output logic [3:0]          data,
  output logic                frame_start
);

  localparam int DW = $clog2(DWELL);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF    = {8{SEG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [DW-1:0]       dwell;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic                started;
  logic                pend;
  logic                boundary;
  logic [4*DIGITS-1:0] pend_value, act_value;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blink, act_blink;
  logic                pend_lz, act_lz;

  assign boundary = (dwell == DWELL_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      idx     <= '0;
      fcnt    <= '0;
      phase   <= 1'b0;
      started <= 1'b0;
    end else begin
      dwell <= (dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
      if (dwell == DWELL_LAST) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (boundary) begin
        started <= 1'b1;
        if (fcnt == FRAME_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // A load landing on the boundary cycle skips the pending stage entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_lz    <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
      act_lz     <= 1'b0;
    end else if (boundary && load) begin
      act_value <= value;
      act_dp    <= dp;
      act_blink <= blink_en;
      act_lz    <= blank_lz;
      pend      <= 1'b0;
    end else if (boundary && pend) begin
      act_value <= pend_value;
      act_dp    <= pend_dp;
      act_blink <= pend_blink;
      act_lz    <= pend_lz;
      pend      <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp;
      pend_blink <= blink_en;
      pend_lz    <= blank_lz;
      pend       <= 1'b1;
    end
  end

  logic [DIGITS-1:0] sel;
  logic [3:0]        nib;
  logic              dp_bit, blink_bit, blank, zero_hi;
  logic [7:0]        seg_on;
  logic [DIGITS-1:0] choose_p0;
  logic [7:0]        seg_p0;
  logic [3:0]        data_p0;
  logic              fs_p0;

  // Stage p0: select the current digit and build its segment pattern.
  always_comb begin
    sel       = '0;
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blink_bit = 1'b0;
    blank     = 1'b0;
    zero_hi   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_hi = zero_hi & (act_value[4*k +: 4] == 4'h0);
      if (IW'(k) == idx) begin
        sel[k]    = 1'b1;
        nib       = act_value[4*k +: 4];
        dp_bit    = act_dp[k];
        blink_bit = act_blink[k];
        blank     = act_lz && zero_hi && (k != 0);
      end
    end
    seg_on = {dp_bit, blank ? 7'h00 : hex_to_seg(nib)};
    if (phase && blink_bit) seg_on = 8'h00;
    choose_p0 = sel ^ SEL_OFF;
    seg_p0    = seg_on ^ SEG_OFF;
    data_p0   = nib;
    fs_p0     = started && (dwell == '0) && (idx == '0);
  end

  // Stage p1: registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      choose      <= SEL_OFF;
      seg         <= SEG_OFF;
      data        <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      choose      <= choose_p0;
      seg         <= seg_p0;
      data        <= data_p0;
      frame_start <= fs_p0;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=4, DWELL=4, BLINK_FRAMES=2, active-low pins).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp, blink_en;
  logic        blank_lz, load;
  logic [3:0]  choose;
  logic [7:0]  seg;
  logic [3:0]  data;
  logic        frame_start;

  seg_scan #(
    .DIGITS(4), .DWELL(4), .BLINK_FRAMES(2), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blink_en(blink_en),
    .blank_lz(blank_lz), .load(load), .choose(choose), .seg(seg), .data(data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] ch;
    logic [7:0] sg;
    logic [3:0] dt;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Hand-computed per-frame expectations: digit segments (active-low), value, frame_start.
  logic [7:0]  fsg [18][4];
  logic [15:0] fval[18];
  logic        ffs [18];

  task automatic set_f(input int f, input logic [15:0] v, input logic [7:0] s3, s2, s1, s0,
                       input logic fs);
    fval[f] = v;
    fsg[f][3] = s3; fsg[f][2] = s2; fsg[f][1] = s1; fsg[f][0] = s0;
    ffs[f] = fs;
  endtask

  task automatic push_raw(input int c, input logic [3:0] ch, input logic [7:0] sg,
                          input logic [3:0] dt, input logic fs);
    exp_t e;
    e.cyc = c; e.ch = ch; e.sg = sg; e.dt = dt; e.fs = fs;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int f, input int start, input int count);
    logic [3:0]  onehot;
    logic [15:0] v;
    for (int i = 0; i < count; i++) begin
      int d;
      d = i / 4;
      onehot = 4'b0001 << d;
      v = fval[f];
      push_raw(start + i, ~onehot, fsg[f][d], v[4*d +: 4], (i == 0) && ffs[f]);
    end
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missed_sample cyc=%0d got=none want=%0d", cyc, mon_e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("choose", cyc, {4'h0, choose}, {4'h0, mon_e.ch});
      chk("seg", cyc, seg, mon_e.sg);
      chk("data", cyc, {4'h0, data}, {4'h0, mon_e.dt});
      chk("frame_start", cyc, {7'h0, frame_start}, {7'h0, mon_e.fs});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic lz);
    load = 1'b1; value = v; dp = d; blink_en = b; blank_lz = lz;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; value = '0; dp = '0; blink_en = '0; blank_lz = 1'b0; load = 1'b0;

    set_f(0,  16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
    set_f(1,  16'h1234, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b1);
    set_f(2,  16'h1234, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b1);
    set_f(3,  16'h1234, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b1);
    set_f(4,  16'hABCD, 8'h88, 8'h83, 8'hC6, 8'hA1, 1'b1);
    set_f(5,  16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);
    set_f(6,  16'h0050, 8'hFF, 8'hFF, 8'h92, 8'hC0, 1'b1);
    set_f(7,  16'h0000, 8'hFF, 8'h7F, 8'hFF, 8'hC0, 1'b1);
    set_f(8,  16'h8888, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    set_f(9,  16'h8888, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    set_f(10, 16'h8888, 8'h80, 8'h80, 8'h80, 8'hFF, 1'b1);
    set_f(11, 16'h8888, 8'h80, 8'h80, 8'h80, 8'hFF, 1'b1);
    set_f(12, 16'h8888, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    set_f(13, 16'h5555, 8'h92, 8'h92, 8'h92, 8'h92, 1'b1);
    set_f(14, 16'h5555, 8'h92, 8'h92, 8'h92, 8'h92, 1'b1);
    set_f(15, 16'h5555, 8'h92, 8'h92, 8'h92, 8'h92, 1'b1);
    set_f(16, 16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
    set_f(17, 16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);

    push_raw(1, 4'hF, 8'hFF, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = cyc;

    for (int n = 0; n <= 252; n++) begin
      load = 1'b0;
      if ((n % 16 == 0) && (n <= 240)) push_frame(n / 16, base + n + 1, (n == 240) ? 8 : 16);
      case (n)
        0:   do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        53:  do_load(16'hABCD, 4'b0000, 4'b0000, 1'b0);
        66:  do_load(16'h9999, 4'b0000, 4'b0000, 1'b0);
        70:  do_load(16'h0000, 4'b0000, 4'b0000, 1'b0);
        82:  do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
        98:  do_load(16'h0000, 4'b0100, 4'b0000, 1'b1);
        114: do_load(16'h8888, 4'b0000, 4'b0001, 1'b0);
        200: do_load(16'h7777, 4'b0000, 4'b0000, 1'b0);
        207: do_load(16'h5555, 4'b0000, 4'b0000, 1'b0);
        244: do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        249: begin
          rst_n = 1'b0;
          for (int r = 0; r < 4; r++) push_raw(base + 249 + r, 4'hF, 8'hFF, 4'h0, 1'b0);
        end
        252: begin
          rst_n = 1'b1;
          base = cyc;
          push_frame(16, base + 1, 16);
          push_frame(17, base + 17, 16);
        end
        default: ;
      endcase
      step();
    end
    load = 1'b0;
    repeat (33) step();

    for (int k = 0; k < 50 && sb.size() > 0; k++) step();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout cyc=%0d got=%0d_left want=0_left", cyc, sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised multiplexed seven-segment display driver for the board's debug display. It time-multiplexes `DIGITS` hex nibbles onto a shared segment bus and decodes each nibble to segments internally. It double-buffers the displayed value so updates take effect only at frame boundaries. It adds per-digit decimal points, leading-zero blanking and per-digit blinking. It sits between the CPU debug/register-readout path and the board's digit-select and segment pins.

## Interface
- `DIGITS`, 4: number of digits, 1..8.
- `DWELL`, 100000: clock cycles each digit stays selected, ≥2.
- `BLINK_FRAMES`, 64: frames per blink half-period, ≥1.
- `SEL_ACTIVE_LOW`, 1: 1 means a selected digit drives 0 on `choose`.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment drives 0 on `seg`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `value`  in  4*DIGITS  nibble k = `value[4k+3:4k]` is shown on digit k; digit 0 is least significant.
- `dp`  in  DIGITS  decimal-point enable per digit.
- `blink_en`  in  DIGITS  blink enable per digit.
- `blank_lz`  in  1  leading-zero blanking enable.
- `load`  in  1  one-cycle strobe that captures `value`, `dp`, `blink_en` and `blank_lz`.
- `choose`  out  DIGITS  one-hot digit select, polarity per `SEL_ACTIVE_LOW`.
- `seg`  out  8  segments; bit 0..6 = a..g, bit 7 = dp; polarity per `SEG_ACTIVE_LOW`.
- `data`  out  4  nibble of the currently selected digit, for debug.
- `frame_start`  out  1  one-cycle pulse in the first cycle digit 0 is selected in each frame.

## Operation
- **Dwell counter:** `dwell` counts 0..DWELL-1 and wraps to 0.
- **Digit index:** `idx` advances on each `dwell` wrap, 0..DIGITS-1, then wraps to 0.
- **Frame:** one frame = DIGITS*DWELL cycles.
- **Boundary cycle:** the cycle where `dwell`==DWELL-1 and `idx`==DIGITS-1.
- **Double buffering:**
  - `load` copies the inputs into the pending registers and sets `pend`.
  - On the boundary cycle, if `pend` is set, pending is copied to the active registers and `pend` clears.
  - Repeated loads within one frame: the last one wins.
  - `load` on the boundary cycle itself bypasses pending: the inputs go straight to the active registers and `pend` clears.
- **Decode** (active-high, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Leading-zero blanking** (active `blank_lz` set):
  - Digit k is blank when every active nibble at index ≥k is zero and k≠0.
  - Digit 0 is never blanked.
  - A blanked digit shows segments a..g off; dp is still shown if its `dp` bit is set.
- **Blink:**
  - A frame counter toggles `phase` every BLINK_FRAMES frames.
  - While `phase`=1, digits with active `blink_en` set show all 8 segments off. `choose` still scans normally.
- **Select width:** exactly one `choose` bit is asserted at any time after reset.

## Timing
- `choose`, `seg`, `data` and `frame_start` are registered.
- They reflect the new `idx` in the cycle after `dwell` wraps, i.e. one cycle of latency from the index change.
- Reset values:
  - `dwell`=0, `idx`=0, `phase`=0, `pend`=0.
  - Active and pending registers all 0.
  - `choose` = all digits deselected.
  - `seg` = all segments off.
  - `data`=0, `frame_start`=0.
- **First cycle after reset release:** `choose` selects digit 0 and `seg` shows the active nibble 0 ("0", 3F before polarity). No `frame_start` pulse for this first frame.
- Each digit stays selected for exactly DWELL cycles.
- `frame_start` pulses every DIGITS*DWELL cycles, starting with the second frame.
- **Loaded value visible:** on `choose`/`seg` in the first cycle of the next frame, same cycle as `frame_start`.
- **Blink phase:** toggles on the boundary cycle; the effect is visible with the same one-cycle output latency.
- **`rst_n` low mid-frame:** outputs go to reset values immediately (asynchronously). Pending and active contents are lost.
- `DIGITS`=1: `idx` stays 0; the boundary occurs every DWELL cycles.

## Test plan
Configuration unless stated: DIGITS=4, DWELL=4, BLINK_FRAMES=2, both polarities active-low.
- **Reset and scan:** reset, then `load` with `value`=16'h1234, then run 3 frames.
  - `choose` cycles 1110,1101,1011,0111 at 4 cycles each.
  - From the second frame, `seg` = ~66,~4F,~5B,~06.
  - `frame_start` pulses every 16 cycles.
- **Mid-frame load:** `load` 16'hABCD while digit 1 is selected.
  - The rest of the frame still shows 1234.
  - The next frame shows ~5E,~39,~7C,~77.
  - A second `load` 16'h0000 in the same frame takes precedence.
- **Leading-zero blanking:** `blank_lz`=1.
  - `value`=16'h0050: digits 3 and 2 show 0xFF, digit 1 shows ~6D, digit 0 shows ~3F.
  - `value`=0 with `dp`=4'b0100: digit 2 shows ~80 only; digit 0 shows ~3F.
- **Blink:** `blink_en`=4'b0001, `value`=16'h8888.
  - Digit 0 alternates ~7F / 0xFF every 2 frames.
  - Digits 1..3 stay ~7F throughout.
- **Boundary load:** `load` 16'h5555 exactly on the boundary cycle.
  - The next frame's digit 0 shows ~6D.
  - `pend` is clear afterwards.
- **Reset mid-operation:** drop `rst_n` while digit 2 is selected.
  - `choose`=1111 and `seg`=0xFF asynchronously.
  - After release, digit 0 shows ~3F.
